if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage; drives the IF/ID pipeline register. Holds the PC, issues requests to
//  instruction memory (req/ack), presents {instr, PC+STEP} with a valid flag, obeys ID stall,
//  and redirects on taken branch. Two-entry output (out reg + skid) so no fetched word is lost.
// PARAMETERS
//  INSTR_W   32     instruction width
//  PC_W      8      PC width (matches IF/ID PC field)
//  PC_STEP   4      PC increment per instruction
//  RESET_PC  0      PC value after reset
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  imem_req     out  1        fetch request; held until imem_ack
//  imem_addr    out  PC_W     fetch address; stable while imem_req=1
//  imem_ack     in   1        data valid this cycle (may be same cycle as req)
//  imem_rdata   in   INSTR_W  fetched instruction
//  id_stall     in   1        ID cannot accept; holds if_* outputs
//  br_taken     in   1        redirect/flush (1-cycle pulse)
//  br_target    in   PC_W     redirect PC
//  if_instr     out  INSTR_W  instruction to IF/ID
//  if_pc        out  PC_W     PC+PC_STEP of if_instr, to IF/ID
//  if_valid     out  1        if_instr/if_pc valid
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=REQ, if_valid=0, if_instr=0, if_pc=0, skid empty,
//   imem_req=0 while in reset. First request cycle after rst_n rises.
//  Transfer: occurs at clk edge where if_valid=1 && id_stall=0. Outputs registered, held otherwise.
//  State REQ: imem_req=1, imem_addr=pc. On imem_ack (no br_taken):
//   - out slot free or transferring this edge -> out<=rdata/pc+STEP, if_valid=1; stay REQ.
//   - out slot held (stall) -> skid<=rdata/pc+STEP, go FULL.
//   - pc<=pc+PC_STEP (wraps mod 2^PC_W, no error).
//  State FULL: imem_req=0. On transfer: out<=skid, skid empty, go REQ.
//  State DROP: imem_req=1, imem_addr=saved old addr; on ack discard data, go REQ.
//  br_taken (highest priority, any state): if_valid<=0, skid cleared, pc<=br_target.
//   - REQ, ack same cycle: data discarded, stay REQ (next addr = br_target).
//   - REQ, no ack: go DROP (old request must complete; addr not changed mid-request).
//   - FULL or DROP: go REQ / stay DROP respectively.
//   - a transfer coinciding with br_taken still completes to ID (ID flushes it).
//  id_stall ignored when if_valid=0. Latency: ack -> if_valid next edge (1 cycle).
//  Throughput: 1 instr/cycle with single-cycle ack and no stall.
//  At most 2 fetched, unconsumed words (out + skid); no request issued in FULL.
//  rst_n asserted mid-request: req drops immediately; outstanding ack after reset ignored
//   only if it arrives before req re-asserts.
// TESTING
//  1 Reset, ack=req comb., stall=0, rdata=0x1000+addr -> if_pc 4,8,12.. consecutive, valid every cycle.
//  2 Stall 3 cycles with valid=1, ack continuous -> one word in skid, req=0 in FULL, no loss/dup.
//  3 br_taken target=0x40 while ack pending (2-cycle ack) -> DROP, old data discarded, next addr=0x40.
//  4 br_taken with same-cycle ack and skid full -> if_valid=0 next cycle, skid empty, addr=target.
//  5 PC at 0xFC, PC_STEP=4 -> next addr 0x00, if_pc=0x00; rst_n low mid-FULL -> all outputs reset.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Holds the PC and runs a req/ack handshake to instruction memory.
// Each fetched word is presented to ID as {instr, PC+STEP} with a valid flag.
// A two-entry buffer (output register plus skid register) absorbs one word
// fetched while ID is stalled, so no fetched word is ever dropped.
// A taken branch flushes both entries and redirects the PC. If a request is
// still outstanding when the branch arrives, that request is first completed
// and its data thrown away.
module if_fetch_unit #(
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned PC_W     = 8,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned RESET_PC = 32'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_valid
);

  localparam logic [PC_W-1:0] STEP    = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);

  // REQ : a fetch is requested at pc.
  // FULL: both output entries are occupied, so no request is made.
  // DROP: a request made before a branch is completed and its data discarded.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_FULL = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Next sequential PC; wraps modulo 2^PC_W by design.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + STEP;
  endfunction

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    opc_q, opc_d;
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;

  logic transfer_s;
  logic accept_s;

  // ID takes the output word at this edge.
  assign transfer_s = valid_q && !id_stall;
  // Memory acks count only while the request line is up. This ignores a stale
  // ack that arrives after reset but before the request has been raised again.
  assign accept_s   = req_q && imem_ack;

  // Next-state computation: fetch handshake, output/skid movement and redirect.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    opc_d        = opc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    // A word handed to ID leaves the output slot unless it is refilled below.
    if (transfer_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_REQ: begin
        if (br_taken) begin
          valid_d      = 1'b0;
          skid_valid_d = 1'b0;
          pc_d         = br_target;
          if (req_q && !imem_ack) begin
            // Keep the old address on the bus until memory answers.
            state_d = ST_DROP;
          end else begin
            // Either the request finished this edge (its data is dropped)
            // or no request was active, so fetch the target next.
            state_d = ST_REQ;
            addr_d  = br_target;
          end
        end else if (accept_s) begin
          pc_d   = pc_inc(pc_q);
          addr_d = pc_inc(pc_q);
          if (!valid_q || transfer_s) begin
            instr_d = imem_rdata;
            opc_d   = pc_inc(pc_q);
            valid_d = 1'b1;
            state_d = ST_REQ;
          end else begin
            // The output slot is held by the stall, so park the word.
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_inc(pc_q);
            skid_valid_d = 1'b1;
            state_d      = ST_FULL;
          end
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_FULL: begin
        if (br_taken) begin
          valid_d      = 1'b0;
          skid_valid_d = 1'b0;
          pc_d         = br_target;
          addr_d       = br_target;
          state_d      = ST_REQ;
        end else if (transfer_s) begin
          instr_d      = skid_instr_q;
          opc_d        = skid_pc_q;
          valid_d      = 1'b1;
          skid_valid_d = 1'b0;
          state_d      = ST_REQ;
        end else begin
          state_d = ST_FULL;
        end
      end

      ST_DROP: begin
        if (br_taken) begin
          valid_d      = 1'b0;
          skid_valid_d = 1'b0;
          pc_d         = br_target;
        end else begin
          pc_d = pc_q;
        end
        if (accept_s) begin
          // The stale request is done; the next fetch uses the newest target.
          state_d = ST_REQ;
          if (br_taken) begin
            addr_d = br_target;
          end else begin
            addr_d = pc_q;
          end
        end else begin
          state_d = ST_DROP;
        end
      end

      default: begin
        state_d      = ST_REQ;
        valid_d      = 1'b0;
        skid_valid_d = 1'b0;
        pc_d         = PC_INIT;
        addr_d       = PC_INIT;
      end
    endcase

    // The request line is registered and stays low only while both entries are full.
    if (state_d == ST_FULL) begin
      req_d = 1'b0;
    end else begin
      req_d = 1'b1;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_REQ;
      pc_q         <= PC_INIT;
      addr_q       <= PC_INIT;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      opc_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      opc_q        <= opc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_instr  = instr_q;
  assign if_pc     = opc_q;
  assign if_valid  = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit. The reference model keeps a queue of the
// words that have been fetched but not yet consumed by ID, the next useful
// fetch address, and a flag for a request that must be drained and dropped.
// Directed sequences pin known values; a randomized phase then stresses
// stalls, acks, branches and resets.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        br_taken;
  logic [7:0]  br_target;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic        if_valid;

  logic comb_mode;
  logic ack_en;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
  } ent_t;

  ent_t       q[$];
  logic [7:0] exp_pc;
  logic [7:0] drop_addr;
  bit         drop;
  bit         req_en;

  if_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_stall   (id_stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_valid   (if_valid)
  );

  // Memory: the content at address a is 0x1000 + a. Ack either follows req or is free-running.
  assign imem_rdata = 32'h0000_1000 + {24'd0, imem_addr};
  assign imem_ack   = comb_mode ? imem_req : ack_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [7:0] a);
    return 32'h0000_1000 + {24'd0, a};
  endfunction

  // Compare process: at each falling edge, check the outputs against the model,
  // then advance the model with the inputs that will be sampled at the next rising edge.
  initial begin
    bit   exp_req;
    bit   acc;
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc",    {24'd0, if_pc}, 32'd0);
        q.delete();
        drop   = 1'b0;
        exp_pc = 8'h00;
        req_en = 1'b0;
      end else begin
        if (q.size() > 2) begin
          chk("occupancy", q.size(), 32'd2);
        end
        exp_req = req_en && (q.size() < 2);
        chk("req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) begin
          chk("addr", {24'd0, imem_addr}, {24'd0, (drop ? drop_addr : exp_pc)});
        end
        chk("valid", {31'd0, if_valid}, {31'd0, (q.size() > 0)});
        if (q.size() > 0) begin
          chk("instr", if_instr, q[0].instr);
          chk("pc",    {24'd0, if_pc}, {24'd0, q[0].pc});
        end
        // Model update for the coming rising edge.
        acc = exp_req && imem_ack;
        if ((q.size() > 0) && !id_stall) begin
          void'(q.pop_front());
        end
        if (br_taken) begin
          q.delete();
          if (exp_req && !imem_ack) begin
            if (!drop) drop_addr = exp_pc;
            drop = 1'b1;
          end else begin
            drop = 1'b0;
          end
          exp_pc = br_target;
        end else if (acc) begin
          if (drop) begin
            drop = 1'b0;
          end else begin
            e.instr = mem(exp_pc);
            e.pc    = exp_pc + 8'd4;
            q.push_back(e);
            exp_pc  = exp_pc + 8'd4;
          end
        end
        req_en = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Stimulus: directed scenarios with literal expectations, then a random phase.
  initial begin
    rst_n     = 1'b0;
    comb_mode = 1'b1;
    ack_en    = 1'b0;
    id_stall  = 1'b0;
    br_taken  = 1'b0;
    br_target = 8'h00;
    cyc();
    cyc();
    chk("d_rst_req",   {31'd0, imem_req}, 32'd0);
    chk("d_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("d_rst_addr",  {24'd0, imem_addr}, 32'd0);
    rst_n = 1'b1;

    // Sequential fetch with single-cycle ack.
    cyc();
    chk("d_first_req",  {31'd0, imem_req}, 32'd1);
    chk("d_first_addr", {24'd0, imem_addr}, 32'd0);
    cyc();
    chk("d_pc4",    {24'd0, if_pc}, 32'h04);
    chk("d_instr0", if_instr, 32'h1000);
    cyc();
    chk("d_pc8",    {24'd0, if_pc}, 32'h08);
    cyc();
    chk("d_pc12",   {24'd0, if_pc}, 32'h0C);
    chk("d_v12",    {31'd0, if_valid}, 32'd1);

    // Three-cycle stall: one word goes to the skid and no request is made.
    id_stall = 1'b1;
    cyc();
    chk("d_full_req",  {31'd0, imem_req}, 32'd0);
    chk("d_held_pc",   {24'd0, if_pc}, 32'h0C);
    cyc();
    cyc();
    chk("d_held_pc2",  {24'd0, if_pc}, 32'h0C);
    id_stall = 1'b0;
    cyc();
    chk("d_skid_pc",   {24'd0, if_pc}, 32'h10);
    chk("d_skid_req",  {31'd0, imem_req}, 32'd1);
    chk("d_skid_addr", {24'd0, imem_addr}, 32'h10);
    cyc();
    chk("d_after_pc",  {24'd0, if_pc}, 32'h14);

    // Branch while the ack is still pending: the old request drains, then the target is fetched.
    comb_mode = 1'b0;
    ack_en    = 1'b0;
    br_taken  = 1'b1;
    br_target = 8'h40;
    cyc();
    br_taken = 1'b0;
    chk("d_drop_valid", {31'd0, if_valid}, 32'd0);
    chk("d_drop_addr",  {24'd0, imem_addr}, 32'h14);
    cyc();
    chk("d_drop_addr2", {24'd0, imem_addr}, 32'h14);
    ack_en = 1'b1;
    cyc();
    chk("d_drop_dis",   {31'd0, if_valid}, 32'd0);
    chk("d_tgt_addr",   {24'd0, imem_addr}, 32'h40);
    cyc();
    chk("d_tgt_pc",     {24'd0, if_pc}, 32'h44);
    chk("d_tgt_instr",  if_instr, 32'h1040);

    // Branch while the skid is full: both entries are flushed.
    id_stall = 1'b1;
    cyc();
    chk("d_full2_req", {31'd0, imem_req}, 32'd0);
    br_taken  = 1'b1;
    br_target = 8'h80;
    cyc();
    br_taken = 1'b0;
    id_stall = 1'b0;
    chk("d_flush_valid", {31'd0, if_valid}, 32'd0);
    chk("d_flush_addr",  {24'd0, imem_addr}, 32'h80);
    cyc();
    chk("d_flush_pc",    {24'd0, if_pc}, 32'h84);

    // PC wrap at the top of the address space, then reset while FULL.
    comb_mode = 1'b1;
    br_taken  = 1'b1;
    br_target = 8'hF8;
    cyc();
    br_taken = 1'b0;
    chk("d_same_ack_valid", {31'd0, if_valid}, 32'd0);
    chk("d_same_ack_addr",  {24'd0, imem_addr}, 32'hF8);
    cyc();
    chk("d_pcFC", {24'd0, if_pc}, 32'hFC);
    cyc();
    chk("d_wrap_pc",    {24'd0, if_pc}, 32'h00);
    chk("d_wrap_instr", if_instr, 32'h10FC);
    chk("d_wrap_addr",  {24'd0, imem_addr}, 32'h00);
    id_stall = 1'b1;
    cyc();
    chk("d_full3_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("d_mid_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("d_mid_rst_pc",    {24'd0, if_pc}, 32'd0);
    chk("d_mid_rst_instr", if_instr, 32'd0);
    chk("d_mid_rst_req",   {31'd0, imem_req}, 32'd0);
    id_stall = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if ((i % 500) == 0) comb_mode = ($urandom_range(0, 1) == 1);
      id_stall  = ($urandom_range(0, 99) < 30);
      ack_en    = ($urandom_range(0, 99) < 60);
      br_taken  = ($urandom_range(0, 99) < 6);
      br_target = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
      end
    end
    br_taken = 1'b0;
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
